packet_matrix_arbiter: RTL and testbench
========================================

// Module: packet_matrix_arbiter
//
// PURPOSE
// - NUM-way least-recently-granted matrix arbiter with packet locking, for NoC router output ports.
// - A grant issued on a packet's first beat is held until that requester transfers its i_last beat.
// - Priority is updated only when a packet completes.
// - Downstream backpressure is taken via i_ready.
// - Sits between the per-input VC/route logic and the output crossbar select.
//
// PARAMETERS
// - NUM       4    number of requesters (>=1)
// - MAX_LOCK  255  watchdog limit: stalled locked cycles before forced release (watchdog build only)
// - IDX_W     derived = max(1,$clog2(NUM)); width of o_gnt_idx
//
// PORTS
// - clk        in   1      clock
// - rst        in   1      synchronous reset, active-high
// - i_req      in   NUM    per-requester beat valid
// - i_last     in   NUM    per-requester: current beat is the packet's last
// - i_ready    in   1      downstream accepts the granted beat this cycle
// - o_gnt      out  NUM    one-hot grant (or zero)
// - o_gnt_idx  out  IDX_W  binary index of o_gnt; 0 when o_gnt==0
// - o_locked   out  1      registered: arbiter is mid-packet
// - o_timeout  out  1      one-cycle pulse on watchdog release
//
// BEHAVIOUR
// - Priority state: NUM*(NUM-1)/2 regs; m[i][j]=1 => i beats j.
//   Reset: m[i][j]=1 for i<j, so index 0 is highest.
// - Transfer (xfer) = |(o_gnt & i_req) & i_ready. Winner w = o_gnt_idx.
// - State UNLOCKED (o_locked=0):
//   - o_gnt[i] = i_req[i] & ~|{i_req[j] & m[j][i], j!=i}. Combinational, 0-cycle latency.
//   - No xfer: no state change.
//   - xfer & i_last[w]: update matrix, stay UNLOCKED.
//   - xfer & ~i_last[w]: owner<=w, go LOCKED.
// - State LOCKED:
//   - o_gnt = onehot(owner), independent of i_req and matrix.
//   - Owner dropping i_req keeps the grant; no xfer occurs.
//   - xfer & i_last[owner]: update matrix for owner, go UNLOCKED.
//     The next packet is arbitrated combinationally in the following cycle.
// - Matrix update for w: m[w][j]<=0 and m[j][w]<=1 for all j!=w. w becomes lowest priority.
// - Single-beat packets (i_last on first beat) never lock.
// - i_ready low: grant stable while locked; no priority change in either state.
// - Reset (any cycle, incl. mid-packet):
//   - Next edge: matrix to default, UNLOCKED, owner=0, watchdog count=0.
//   - While rst is high: o_gnt=0, o_gnt_idx=0, o_locked=0, o_timeout=0.
// - NUM=1: matrix empty; o_gnt=i_req; locking still applies.
//
// CONFIGURATION
// - Macro PACKET_MATRIX_ARBITER_WATCHDOG_EN defined:
//   - LOCKED cycles without xfer count up from 0; any xfer clears the count.
//   - Count reaching MAX_LOCK: force UNLOCKED, demote owner in matrix, o_timeout=1 for exactly that edge's next cycle.
//   - xfer in the same cycle as expiry takes precedence (normal handling, no timeout).
// - Macro not defined: no counter; o_timeout tied 0; lock held indefinitely.
//
// TESTING
// - Reset 2 cycles, i_req=0000 -> o_gnt=0000, o_gnt_idx=0, o_locked=0.
// - i_req=1111, i_last=1111, i_ready=1 -> o_gnt 0001,0010,0100,1000,0001... per cycle.
// - i_req=0011, i_last[0] low 3 beats then high, i_ready=1 -> o_gnt=0001 for 4 cycles,
//   o_locked=1 cycles 2-4, then o_gnt=0010.
// - Locked on 0100, i_ready=0 for 5 cycles, i_req=1111 -> o_gnt stays 0100.
//   Release with i_ready=1+i_last -> next winner is the highest-priority remaining requester.
// - WATCHDOG_EN, MAX_LOCK=8: lock on 0001, i_ready=0 -> o_timeout pulse once after 8 stalled cycles;
//   then o_gnt=0010 with i_req=0011.
// - rst mid-packet (locked on 1000) -> o_locked=0 after the edge; with i_req=1111 o_gnt=0001.

Source files
------------

// File: rtl/packet_matrix_arbiter.sv
// Least-recently-granted matrix arbiter with packet locking for a NoC output port.
// Optional stall watchdog enabled by defining PACKET_MATRIX_ARBITER_WATCHDOG_EN.
module packet_matrix_arbiter #(
  parameter int NUM      = 4,
  parameter int MAX_LOCK = 255,
  parameter int IDX_W    = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   i_req,
  input  logic [NUM-1:0]   i_last,
  input  logic             i_ready,
  output logic [NUM-1:0]   o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int PAIRS = (NUM > 1) ? NUM * (NUM - 1) / 2 : 1;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;

  state_t             r_state, w_next_state;
  logic [PAIRS-1:0]   r_tri;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM-1:0]     w_beaten_by [NUM];
  logic [NUM-1:0]     w_arb, w_owner_oh, w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_xfer, w_last, w_release, w_expire;

  // Upper triangle only: bit (i,j) with i<j holds m[i][j]; m[j][i] is its inverse.
  function automatic logic [PW-1:0] pair_idx(input int i, input int j);
    return PW'(i * NUM - (i * (i + 1)) / 2 + (j - i - 1));
  endfunction

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      w_beaten_by[i] = '0;
      for (int j = 0; j < NUM; j++) begin
        if (j < i)      w_beaten_by[i][j] = r_tri[pair_idx(j, i)];
        else if (j > i) w_beaten_by[i][j] = ~r_tri[pair_idx(i, j)];
      end
    end
  end

  always_comb begin
    w_arb      = '0;
    w_owner_oh = '0;
    for (int i = 0; i < NUM; i++) begin
      w_arb[i]      = i_req[i] & ~|(i_req & w_beaten_by[i]);
      w_owner_oh[i] = (r_owner == IDX_W'(i));
    end
  end

  always_comb begin
    if (rst)                      w_gnt = '0;
    else if (r_state == S_LOCKED) w_gnt = w_owner_oh;
    else                          w_gnt = w_arb;
    w_idx = '0;
    for (int i = 0; i < NUM; i++)
      if (w_gnt[i]) w_idx = IDX_W'(i);
  end

  assign w_xfer    = |(w_gnt & i_req) & i_ready;
  assign w_last    = |(w_gnt & i_last);
  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;
  assign o_locked  = (r_state == S_LOCKED) & ~rst;

  always_comb begin
    w_next_state = r_state;
    w_release    = 1'b0;
    case (r_state)
      S_UNLOCKED: begin
        if (w_xfer && w_last)  w_release = 1'b1;
        else if (w_xfer)       w_next_state = S_LOCKED;
      end
      S_LOCKED: begin
        if ((w_xfer && w_last) || w_expire) begin
          w_release    = 1'b1;
          w_next_state = S_UNLOCKED;
        end
      end
      default: w_next_state = S_UNLOCKED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_UNLOCKED;
      r_tri   <= '1;
      r_owner <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_UNLOCKED && w_xfer && !w_last) r_owner <= w_idx;
      if (w_release) begin
        // Winner loses to everyone: m[w][j]=0, m[j][w]=1.
        for (int i = 0; i < NUM; i++)
          for (int j = i + 1; j < NUM; j++) begin
            if (IDX_W'(i) == w_idx)      r_tri[pair_idx(i, j)] <= 1'b0;
            else if (IDX_W'(j) == w_idx) r_tri[pair_idx(i, j)] <= 1'b1;
          end
      end
    end
  end

`ifdef PACKET_MATRIX_ARBITER_WATCHDOG_EN
  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Expires on the MAX_LOCK-th consecutive stalled locked cycle; an xfer wins.
  assign w_expire  = (r_state == S_LOCKED) && !w_xfer && (r_cnt == CNT_W'(MAX_LOCK - 1));
  assign o_timeout = r_timeout & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (r_state == S_LOCKED && !w_xfer && !w_expire) r_cnt <= r_cnt + CNT_W'(1);
      else                                             r_cnt <= '0;
    end
  end
`else
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_packet_matrix_arbiter.sv
// Directed self-checking bench for packet_matrix_arbiter (NUM=4, MAX_LOCK=8).
// Watchdog expectations follow PACKET_MATRIX_ARBITER_WATCHDOG_EN.
module tb_packet_matrix_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_req, i_last;
  logic       i_ready;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_idx;
  logic       o_locked, o_timeout;

  int checks   = 0;
  int failures = 0;

  packet_matrix_arbiter #(.NUM(4), .MAX_LOCK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_last    (i_last),
    .i_ready   (i_ready),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx),
    .o_locked  (o_locked),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge and settle before comparing.
  task automatic set(input logic [3:0] req, input logic [3:0] last, input logic rdy);
    i_req   = req;
    i_last  = last;
    i_ready = rdy;
    #1;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] gnt, input logic [1:0] idx,
                            input logic locked);
    check({tag, "_gnt"}, 32'(o_gnt), 32'(gnt));
    check({tag, "_idx"}, 32'(o_gnt_idx), 32'(idx));
    check({tag, "_locked"}, 32'(o_locked), 32'(locked));
  endtask

  logic [3:0] rot_gnt [5];
  logic [1:0] rot_idx [5];

  initial begin
    rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held for two edges; outputs forced low throughout.
    rst = 1'b1;
    set(4'b0000, 4'b0000, 1'b0);
    expect_out("rst_pre", 4'b0000, 2'd0, 1'b0);
    check("rst_pre_timeout", 32'(o_timeout), 32'd0);
    cyc;
    cyc;
    rst = 1'b0;
    set(4'b0000, 4'b0000, 1'b0);
    expect_out("idle", 4'b0000, 2'd0, 1'b0);
    check("idle_timeout", 32'(o_timeout), 32'd0);
    cyc;

    // Single-beat packets from everyone rotate round-robin.
    for (int k = 0; k < 5; k++) begin
      set(4'b1111, 4'b1111, 1'b1);
      expect_out($sformatf("rot%0d", k), rot_gnt[k], rot_idx[k], 1'b0);
      cyc;
    end

    // Reset restores default priority; grant gated while rst high.
    rst = 1'b1;
    set(4'b1111, 4'b1111, 1'b1);
    expect_out("rst_gate", 4'b0000, 2'd0, 1'b0);
    cyc;
    rst = 1'b0;

    // Four-beat packet on requester 0 while 1 also requests.
    set(4'b0011, 4'b0000, 1'b1);
    expect_out("pkt_b1", 4'b0001, 2'd0, 1'b0);
    cyc;
    set(4'b0011, 4'b0000, 1'b1);
    expect_out("pkt_b2", 4'b0001, 2'd0, 1'b1);
    cyc;
    set(4'b0010, 4'b0000, 1'b1);
    expect_out("pkt_owner_drop", 4'b0001, 2'd0, 1'b1);
    cyc;
    set(4'b0011, 4'b0001, 1'b1);
    expect_out("pkt_last", 4'b0001, 2'd0, 1'b1);
    cyc;
    // Priority now 1>2>3>0; single-beat packet from 1 must not lock.
    set(4'b0011, 4'b0010, 1'b1);
    expect_out("pkt_next", 4'b0010, 2'd1, 1'b0);
    cyc;

    // Priority now 2>3>0>1: lock on requester 2, then stall downstream.
    set(4'b1111, 4'b0000, 1'b1);
    expect_out("lock2", 4'b0100, 2'd2, 1'b0);
    cyc;
    for (int k = 0; k < 5; k++) begin
      set(4'b1111, 4'b1111, 1'b0);
      expect_out($sformatf("stall%0d", k), 4'b0100, 2'd2, 1'b1);
      cyc;
    end
    set(4'b1111, 4'b0100, 1'b1);
    expect_out("lock2_last", 4'b0100, 2'd2, 1'b1);
    cyc;

    // Priority now 3>0>1>2; i_ready low while unlocked changes nothing.
    set(4'b1111, 4'b0000, 1'b0);
    expect_out("after_rel", 4'b1000, 2'd3, 1'b0);
    cyc;
    set(4'b1111, 4'b0000, 1'b0);
    expect_out("unlk_noready", 4'b1000, 2'd3, 1'b0);
    cyc;
    set(4'b1111, 4'b0000, 1'b1);
    cyc;
    expect_out("lock3", 4'b1000, 2'd3, 1'b1);

    // Reset mid-packet.
    rst = 1'b1;
    #1;
    expect_out("rst_mid", 4'b0000, 2'd0, 1'b0);
    cyc;
    rst = 1'b0;
    set(4'b1111, 4'b1111, 1'b0);
    expect_out("post_rst", 4'b0001, 2'd0, 1'b0);
    cyc;

    // Lock on 0 then stall 8 cycles to exercise the watchdog.
    set(4'b0011, 4'b0000, 1'b1);
    expect_out("wd_lock", 4'b0001, 2'd0, 1'b0);
    cyc;
    for (int k = 0; k < 8; k++) begin
      set(4'b0011, 4'b0000, 1'b0);
      check($sformatf("wd_stall%0d_gnt", k), 32'(o_gnt), 32'h1);
      check($sformatf("wd_stall%0d_timeout", k), 32'(o_timeout), 32'd0);
      cyc;
    end
`ifdef PACKET_MATRIX_ARBITER_WATCHDOG_EN
    expect_out("wd_expired", 4'b0010, 2'd1, 1'b0);
    check("wd_pulse", 32'(o_timeout), 32'd1);
`else
    expect_out("wd_absent", 4'b0001, 2'd0, 1'b1);
    check("wd_pulse", 32'(o_timeout), 32'd0);
`endif
    cyc;
    check("wd_pulse_end", 32'(o_timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
